// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg: shared state encoding, modulus floor and clamp helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam int unsigned MIN_MOD = 2;

    function automatic int unsigned clamp_mod(input int unsigned m);
        return (m < MIN_MOD) ? MIN_MOD : m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_controller_if.sv
// ---------------------------------------------------------------------------
// divider_controller_if: control, config handshake and status bundle.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divider_controller_if #(
    parameter int WIDTH = 3
);
    logic             start_i;
    logic             stop_i;
    logic             cfg_valid_i;
    logic [WIDTH-1:0] cfg_mod_i;
    logic             cfg_ready_o;
    logic [WIDTH-1:0] count_o;
    logic             tick_o;
    logic             out_o;
    logic             busy_o;
    logic [1:0]       state_o;

    modport master (
        output start_i, stop_i, cfg_valid_i, cfg_mod_i,
        input  cfg_ready_o, count_o, tick_o, out_o, busy_o, state_o
    );

    modport slave (
        input  start_i, stop_i, cfg_valid_i, cfg_mod_i,
        output cfg_ready_o, count_o, tick_o, out_o, busy_o, state_o
    );
endinterface

`default_nettype wire

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter: enable/clear counter that wraps to 0 after mod-1.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wrap_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] mod_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_last;

    assign w_last = (count_q == (mod_i - WIDTH'(1)));
    assign wrap_o = en_i & w_last;

    // Clear dominates so the controller can resync count on any state change.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = w_last ? '0 : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/divider_controller.sv
// ---------------------------------------------------------------------------
// divider_controller: IDLE/RUN/PAUSE clock divider with shadowed modulus.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider_controller
    import divider_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int DEFAULT_MOD = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    divider_controller_if.slave  bus
);
    state_e           state_q;
    logic             out_q;
    logic             busy_q;
    logic             pending_q;
    logic [WIDTH-1:0] mod_q;
    logic [WIDTH-1:0] shadow_q;

    logic [WIDTH-1:0] w_count;
    logic             w_wrap;
    logic             w_is_idle;
    logic             w_is_run;
    logic             w_is_pause;
    logic             w_cfg_ready;
    logic             w_cfg_acc;
    logic [WIDTH-1:0] w_cfg_mod;
    logic             w_run_to_pause;
    logic             w_apply;
    logic [WIDTH-1:0] w_apply_mod;
    logic             w_range_clr;
    logic             w_start_run;
    logic             w_en;
    logic             w_clr;

    assign w_is_idle   = (state_q == ST_IDLE);
    assign w_is_run    = (state_q == ST_RUN);
    assign w_is_pause  = (state_q == ST_PAUSE);

    assign w_cfg_ready = !pending_q;
    assign w_cfg_acc   = bus.cfg_valid_i & w_cfg_ready;
    assign w_cfg_mod   = WIDTH'(clamp_mod(32'(bus.cfg_mod_i)));

    assign w_run_to_pause = w_is_run & bus.stop_i;

    // Immediate modulus load: outside RUN, or when leaving RUN for PAUSE
    // (a pending shadow value takes priority on that edge).
    assign w_apply     = (w_run_to_pause & pending_q)
                       | (w_cfg_acc & (!w_is_run | w_run_to_pause));
    assign w_apply_mod = pending_q ? shadow_q : w_cfg_mod;
    assign w_range_clr = w_apply & (w_count >= w_apply_mod);

    assign w_start_run = w_is_idle & bus.start_i & !bus.stop_i;
    assign w_en        = w_is_run & !bus.stop_i;
    assign w_clr       = w_start_run
                       | (w_is_pause & bus.stop_i)
                       | !(w_is_idle | w_is_run | w_is_pause)
                       | w_range_clr;

    wrap_counter #(
        .WIDTH (WIDTH)
    ) u_wrap_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (w_en),
        .clr_i   (w_clr),
        .mod_i   (mod_q),
        .count_o (w_count),
        .wrap_o  (w_wrap)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            pending_q <= 1'b0;
            mod_q     <= WIDTH'(DEFAULT_MOD);
            shadow_q  <= WIDTH'(DEFAULT_MOD);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i && !bus.stop_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop_i) begin
                        state_q <= ST_PAUSE;
                    end else if (w_wrap) begin
                        out_q <= !out_q;
                    end
                end
                ST_PAUSE: begin
                    if (bus.stop_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        out_q   <= 1'b0;
                    end else if (bus.start_i) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    out_q   <= 1'b0;
                end
            endcase

            if (w_apply) begin
                mod_q     <= w_apply_mod;
                pending_q <= 1'b0;
            end else if (w_wrap && pending_q) begin
                mod_q     <= shadow_q;
                pending_q <= 1'b0;
            end

            // Mid-period config waits in the shadow until the next wrap.
            if (w_cfg_acc && w_en) begin
                shadow_q  <= w_cfg_mod;
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.cfg_ready_o = w_cfg_ready;
    assign bus.count_o     = w_count;
    assign bus.tick_o      = w_is_run & (w_count == (mod_q - WIDTH'(1)));
    assign bus.out_o       = out_q;
    assign bus.busy_o      = busy_q;
    assign bus.state_o     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_divider_controller.sv
// ---------------------------------------------------------------------------
// tb_divider_controller: directed stimulus against a per-cycle reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divider_controller;
    localparam int WIDTH = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    divider_controller_if #(.WIDTH(WIDTH)) bus ();

    divider_controller #(
        .WIDTH       (WIDTH),
        .DEFAULT_MOD (6)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_state  = 0;
    int m_count  = 0;
    int m_mod    = 6;
    int m_pend   = 0;
    int m_shadow = 6;
    int m_out    = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply_mod(input int v);
        m_mod  = v;
        m_pend = 0;
        if (m_count >= m_mod) m_count = 0;
    endtask

    // Reference behaviour: 0=IDLE 1=RUN 2=PAUSE, plain integer arithmetic.
    task automatic model_step();
        int nm;
        bit acc, st, sp;
        st  = bus.start_i;
        sp  = bus.stop_i;
        acc = bus.cfg_valid_i && (m_pend == 0);
        nm  = (int'(bus.cfg_mod_i) < 2) ? 2 : int'(bus.cfg_mod_i);
        case (m_state)
            0: begin
                if (acc) m_mod = nm;
                if (st && !sp) begin
                    m_state = 1;
                    m_count = 0;
                end
            end
            1: begin
                if (sp) begin
                    m_state = 2;
                    if (m_pend != 0) apply_mod(m_shadow);
                    else if (acc) apply_mod(nm);
                end else begin
                    if (m_count == m_mod - 1) begin
                        m_count = 0;
                        m_out   = 1 - m_out;
                        if (m_pend != 0) begin
                            m_mod  = m_shadow;
                            m_pend = 0;
                        end
                    end else begin
                        m_count++;
                    end
                    if (acc) begin
                        m_shadow = nm;
                        m_pend   = 1;
                    end
                end
            end
            default: begin
                if (acc) apply_mod(nm);
                if (sp) begin
                    m_state = 0;
                    m_count = 0;
                    m_out   = 0;
                end else if (st) begin
                    m_state = 1;
                end
            end
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_count = 0; m_mod = 6;
            m_pend = 0; m_shadow = 6; m_out = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        check("count", int'(bus.count_o), m_count);
        check("tick", int'(bus.tick_o), int'(m_state == 1 && m_count == m_mod - 1));
        check("out", int'(bus.out_o), m_out);
        check("busy", int'(bus.busy_o), int'(m_state != 0));
        check("state", int'(bus.state_o), m_state);
        check("cfg_ready", int'(bus.cfg_ready_o), int'(m_pend == 0));
    end

    task automatic cyc(input bit s, input bit p, input bit v, input int m);
        bus.start_i     = s;
        bus.stop_i      = p;
        bus.cfg_valid_i = v;
        bus.cfg_mod_i   = 3'(m);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.start_i     = 1'b0;
        bus.stop_i      = 1'b0;
        bus.cfg_valid_i = 1'b0;
        bus.cfg_mod_i   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("pin_reset_mod", m_mod, 6);
        rst_n = 1'b1;

        // Free run at modulus 6
        cyc(1'b1, 1'b0, 1'b0, 0);
        check("pin_start_state", m_state, 1);
        check("pin_start_count", m_count, 0);
        idle(5);
        check("pin_count5", m_count, 5);
        check("pin_out_before_wrap", m_out, 0);
        idle(1);
        check("pin_wrap_count", m_count, 0);
        check("pin_out_after_wrap", m_out, 1);
        idle(6);
        check("pin_out_period12", m_out, 0);

        // Pause holds, resume continues
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("pin_pause_state", m_state, 2);
        check("pin_pause_count", m_count, 3);
        idle(5);
        check("pin_pause_hold", m_count, 3);
        cyc(1'b1, 1'b0, 1'b0, 0);
        idle(1);
        check("pin_resume4", m_count, 4);
        idle(2);
        check("pin_resume_wrap", m_count, 0);

        // Config during RUN is deferred to the wrap
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 4);
        check("pin_pending", m_pend, 1);
        check("dut_cfg_ready_low", int'(bus.cfg_ready_o), 0);
        idle(2);
        check("pin_old_mod_count5", m_count, 5);
        idle(1);
        check("pin_new_mod", m_mod, 4);
        check("dut_cfg_ready_back", int'(bus.cfg_ready_o), 1);
        idle(3);
        check("pin_mod4_top", m_count, 3);
        idle(1);
        check("pin_mod4_wrap", m_count, 0);

        // Back to 6, then config in PAUSE with count clear and clamp
        cyc(1'b0, 1'b0, 1'b1, 6);
        idle(3);
        check("pin_mod6_again", m_mod, 6);
        idle(5);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("pin_pause_at5", m_count, 5);
        cyc(1'b0, 1'b0, 1'b1, 3);
        check("pin_pause_cfg_clear", m_count, 0);
        check("pin_pause_cfg_mod", m_mod, 3);
        cyc(1'b0, 1'b0, 1'b1, 1);
        check("pin_clamp", m_mod, 2);
        cyc(1'b1, 1'b0, 1'b0, 0);
        idle(1);
        check("pin_mod2_1", m_count, 1);
        idle(1);
        check("pin_mod2_0", m_count, 0);
        idle(1);

        // Pending shadow applied on RUN->PAUSE
        cyc(1'b0, 1'b0, 1'b1, 3);
        check("pin_pend_mod2", m_pend, 1);
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("pin_pause_apply", m_mod, 3);
        check("pin_pause_pend_clr", m_pend, 0);

        // PAUSE+stop to IDLE; start+stop in IDLE ignored
        cyc(1'b0, 1'b1, 1'b0, 0);
        check("pin_idle", m_state, 0);
        cyc(1'b1, 1'b1, 1'b0, 0);
        check("pin_both_idle", m_state, 0);

        // Asynchronous reset mid-RUN
        cyc(1'b0, 1'b0, 1'b1, 6);
        cyc(1'b1, 1'b0, 1'b0, 0);
        idle(4);
        check("pin_pre_reset_count", m_count, 4);
        rst_n = 1'b0;
        #1;
        check("async_count", int'(bus.count_o), 0);
        check("async_tick", int'(bus.tick_o), 0);
        check("async_out", int'(bus.out_o), 0);
        check("async_busy", int'(bus.busy_o), 0);
        check("async_state", int'(bus.state_o), 0);
        check("async_cfg_ready", int'(bus.cfg_ready_o), 1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 0);
        check("pin_post_reset_count", m_count, 0);
        idle(2);
        check("pin_post_reset_run", m_count, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/divider_controller.md
DIVIDER_CONTROLLER -- requirements
Module: divider_controller

Interface
REQ-001 Parameter WIDTH, default 3: width of the count and modulus.
REQ-002 Parameter DEFAULT_MOD, default 6: modulus loaded at reset; legal range 2..2^WIDTH-1.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request to begin or resume counting.
REQ-006 stop  input  1  request to pause, or from PAUSE, to return to idle.
REQ-007 cfg_valid  input  1  new modulus offered.
REQ-008 cfg_mod  input  WIDTH  offered modulus.
REQ-009 cfg_ready  output  1  controller can accept a modulus.
REQ-010 count  output  WIDTH  current count value, 0..mod_r-1.
REQ-011 tick  output  1  high on the last count of each period in RUN.
REQ-012 out  output  1  divided clock; toggles on every wrap.
REQ-013 busy  output  1  high when state is not IDLE.
REQ-014 state  output  2  encoded FSM state.

Function
REQ-015 The FSM SHALL have three states: IDLE=0, RUN=1, PAUSE=2; encoding 3 is unreachable and SHALL recover to IDLE.
REQ-016 Transitions SHALL be:
- IDLE + start -> RUN, with count=0.
- RUN + stop -> PAUSE.
- PAUSE + start -> RUN.
- PAUSE + stop -> IDLE, with count=0 and out=0.
REQ-017 If start and stop are high in the same cycle, stop SHALL win; in IDLE both are ignored.
REQ-018 In RUN, count SHALL increment by 1 each cycle. When count==mod_r-1, the next count SHALL be 0 and out SHALL toggle.
REQ-019 tick SHALL be combinational: (state==RUN) & (count==mod_r-1).
REQ-020 In IDLE and PAUSE, count and out SHALL hold; in IDLE, count is 0.
REQ-021 A config handshake SHALL complete when cfg_valid & cfg_ready are high on a rising edge; cfg_ready SHALL equal !pending.
REQ-022 An accepted cfg_mod below 2 SHALL be clamped to 2.
REQ-023 Config accepted in IDLE or PAUSE SHALL load mod_r on the same edge.
- In PAUSE, if the held count >= new mod_r, count SHALL clear to 0.
- pending SHALL stay 0.
REQ-024 Config accepted in RUN SHALL be stored in a shadow register and set pending.
- mod_r SHALL update on the wrap edge (the wrap decision uses the old mod_r).
- pending SHALL clear on that same edge, so cfg_ready returns the following cycle.
REQ-025 If RUN exits to PAUSE while pending=1, the shadow value SHALL be applied on the edge of that transition, under the REQ-023 count-clear rule.
REQ-026 Modulus arithmetic SHALL be unsigned WIDTH bits; count SHALL never reach or exceed mod_r.

Reset
REQ-027 While reset=0, the block SHALL immediately hold:
- count=0, out=0, tick=0, busy=0, state=IDLE, cfg_ready=1.
- mod_r=DEFAULT_MOD, pending=0.
REQ-028 Reset asserted mid-RUN SHALL abort the period with no further tick.
REQ-029 The first active edge after reset release SHALL evaluate inputs normally.

Structure
REQ-030 The state encoding and the constant MIN_MOD=2 SHALL reside in shared package divider_pkg.
REQ-031 The incrementing register with compare-and-wrap SHALL be one sub-module, wrap_counter. Its ports are: clock, reset, en, clr, mod, count, wrap.
- The FSM, the config shadow/pending logic and the out flop SHALL reside in divider_controller.

Verification (WIDTH=3, DEFAULT_MOD=6)
REQ-032 Reset, then a start pulse -> count 0,1,2,3,4,5,0...; tick high when count=5; out period 12 cycles.
REQ-033 RUN at count=2, cfg_mod=4 with cfg_valid -> cfg_ready=0 next cycle; count runs to 5, wraps, then 0..3 repeating; cfg_ready=1 after the wrap.
REQ-034 stop at count=3 -> PAUSE, count holds 3 and tick=0 for 5 cycles; start -> count 4, then 5, 0.
REQ-035 PAUSE at count=5:
- cfg_mod=3 -> count=0, mod_r=3.
- then cfg_mod=1 -> mod_r=2.
- then start -> count 0,1,0,1.
REQ-036 start and stop together in IDLE -> remains IDLE.
REQ-037 reset=0 asserted mid-RUN at count=4 -> all outputs take reset values before the next edge; release then start -> count 0.
